execute_stage: RTL
==================

# execute_stage

Parametrised, handshaked execute stage for the Risky pipeline, sitting between decode/register-read and writeback. It performs arithmetic, logic, shift (including rotate) and memory-access address generation in one cycle. It optionally performs an iterative multi-cycle multiply, with valid/ready back-pressure on both sides and a sticky halt. Results leave through a single registered output slot consumed by the writeback stage.

## Interface
- `DATA_WIDTH`, 16: operand/result width, ≥ 9.
- `ADDRESS_WIDTH`, 10: memory address width, ≤ `DATA_WIDTH`.
- `GPR_WIDTH`, 3: register-index width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: decode offers an instruction.
- `in_ready` out 1: stage accepts; transfer on `in_valid && in_ready` at rising edge.
- `op_class` in 3: 0 ARITH, 1 LOGIC, 2 SHIFT, 3 MEM, 4 MUL, 7 HALT, 5/6 NOP.
- `op_func` in 3: function within class.
- `operand0`, `operand1`, `operand2` in `DATA_WIDTH`: register values.
- `value` in clog2(`DATA_WIDTH`): shift amount.
- `constant` in 8: LOADC immediate.
- `dest_in` in `GPR_WIDTH`: destination register index.
- `out_valid` out 1: output slot full.
- `out_ready` in 1: writeback consumes the slot when `out_valid && out_ready`.
- `result` out `DATA_WIDTH`: computed value.
- `destination` out `GPR_WIDTH`: copy of `dest_in`.
- `writeback` out 2: 0 NONE, 1 REGISTER, 2 MEMORY.
- `read`, `write` out 1: memory strobes, meaningful only while `out_valid`.
- `address` out `ADDRESS_WIDTH`, `data_out` out `DATA_WIDTH`: memory request.
- `halt` out 1: sticky halt.

## Operation
- ARITH: func[0]=0 → `operand1+operand2`; func[0]=1 → `operand1-operand2`. Modulo 2^`DATA_WIDTH`, no flags. Writeback REGISTER.
- LOGIC: func 0..5 → AND, OR, XOR, NAND, NOR, XNOR of `operand1`,`operand2`. Func 6/7 → result 0. Writeback REGISTER.
- SHIFT on `operand0` by `value`: func 0 logical right, 1 arithmetic right, 2 left, 3 rotate left. Func 4–7 → result = `operand0`. Writeback REGISTER.
- MEM:
  - func 0 LOADC: result `{operand0[DATA_WIDTH-1:8], constant}`, writeback REGISTER.
  - func 1 LOAD: `address=operand1[ADDRESS_WIDTH-1:0]`, `read=1`, writeback MEMORY.
  - func 2 STORE: `address=operand0[...]`, `data_out=operand1`, `write=1`, writeback NONE.
  - Other funcs behave as NOP.
- NOP: output slot loaded with writeback NONE; all strobes 0.
- HALT: output slot loaded with writeback NONE. `halt` rises at the same edge and stays high until `reset`.
- MUL (if enabled): low `DATA_WIDTH` bits of `operand1*operand2`, computed by a shift-add with one bit per cycle. Writeback REGISTER.
- Unused output fields for an instruction are driven 0. Strobes and `address`/`data_out` are registered with the slot.
- FSM:
  - IDLE: accepts instructions.
  - MUL_BUSY: counter runs 0..`DATA_WIDTH`-1.
  - MUL_WAIT: product done but slot occupied and not draining.
  - HALTED: terminal until reset.
- FSM transitions:
  - IDLE→MUL_BUSY on MUL accept.
  - MUL_BUSY→IDLE when the last iteration completes and the slot is free (`!out_valid || out_ready`); the product loads into the slot.
  - MUL_BUSY→MUL_WAIT when the last iteration completes and the slot is not free.
  - MUL_WAIT→IDLE when the slot frees.
  - IDLE→HALTED on HALT accept.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`.

## Timing
- Reset (synchronous, at the edge, mid-MUL included): state IDLE, counter 0, and every output 0 (`out_valid`, `result`, `destination`, `writeback`, `read`, `write`, `address`, `data_out`, `halt`). `in_ready` is 1 after reset.
- Single-cycle classes: accepted at edge E, `out_valid` high after edge E.
- Throughput is 1/cycle when `out_ready` is held 1. Accept and drain in the same cycle replace the slot without a bubble.
- MUL accepted at E: `out_valid` high after edge E+`DATA_WIDTH` if the slot is free. Each extra stalled cycle adds one cycle of latency. `in_ready` is 0 throughout.
- Slot contents hold unchanged while `out_valid && !out_ready`.
- `out_valid` clears at a drain edge unless a new result loads at that edge.
- HALT accepted at E: `halt` and `out_valid` high after E, and `in_ready` is 0 from then on.

## Configuration
- `EXEC_MUL_EN` defined: MUL class, the counter, and the MUL_BUSY/MUL_WAIT states are present.
- `EXEC_MUL_EN` undefined: class 4 executes as a single-cycle NOP (writeback NONE), and no multiplier logic is synthesised.

## Test plan
- `DATA_WIDTH`=16 ADD `0x7FFF+0x0001` with `out_ready`=1 → next cycle `result`=`0x8000`, writeback 1. SUB `0x0000-0x0001` → `0xFFFF`.
- SHIFT `operand0`=`0x8001`, `value`=1: SRA → `0xC000`, SRL → `0x4000`, ROTL → `0x0003`.
- LOAD `operand1`=`0x03FF` → `read`=1, `address`=`0x3FF`, writeback 2. Hold `out_ready`=0 for 3 cycles → slot stable and `in_ready`=0 throughout.
- With `EXEC_MUL_EN`: MUL `0x0123*0x0045` → `out_valid` exactly 16 cycles after accept, `result`=`0x4E6F`. Assert `reset` at iteration 8 → all outputs 0 next cycle and `in_ready`=1. Without the macro, the same stimulus gives writeback 0 after 1 cycle.
- HALT followed by an ADD held valid → `halt`=1 after 1 cycle, the ADD is never accepted, and `reset` clears `halt`.
- Back-to-back XOR, NAND, LOADC (`constant`=`0xAB`, `operand0`=`0x1200`) with `out_ready`=1 → three consecutive valid outputs, the last being `0x12AB`.

Source files
------------

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode-side and writeback-side handshake bundle for execute_stage
interface execute_stage_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int GPR_WIDTH     = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [2:0]                    op_class;
    logic [2:0]                    op_func;
    logic [DATA_WIDTH-1:0]         operand0;
    logic [DATA_WIDTH-1:0]         operand1;
    logic [DATA_WIDTH-1:0]         operand2;
    logic [$clog2(DATA_WIDTH)-1:0] value;
    logic [7:0]                    constant;
    logic [GPR_WIDTH-1:0]          dest_in;

    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         result;
    logic [GPR_WIDTH-1:0]          destination;
    logic [1:0]                    writeback;
    logic                          read;
    logic                          write;
    logic [ADDRESS_WIDTH-1:0]      address;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          halt;

    modport master (
        output in_valid, op_class, op_func, operand0, operand1, operand2, value, constant, dest_in,
        output out_ready,
        input  in_ready, out_valid, result, destination, writeback, read, write, address, data_out, halt
    );

    modport slave (
        input  in_valid, op_class, op_func, operand0, operand1, operand2, value, constant, dest_in,
        input  out_ready,
        output in_ready, out_valid, result, destination, writeback, read, write, address, data_out, halt
    );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Risky execute stage: ALU/shift/address generation into one registered output slot.
// Optional shift-add multiplier enabled by defining EXEC_MUL_EN.
module execute_stage #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 10,
    parameter int GPR_WIDTH     = 3
) (
    input  logic           clock,
    input  logic           reset,
    execute_stage_if.slave bus
);
    localparam logic [2:0] CLASS_ARITH = 3'd0;
    localparam logic [2:0] CLASS_LOGIC = 3'd1;
    localparam logic [2:0] CLASS_SHIFT = 3'd2;
    localparam logic [2:0] CLASS_MEM   = 3'd3;
    localparam logic [2:0] CLASS_HALT  = 3'd7;

    localparam logic [1:0] WB_NONE     = 2'd0;
    localparam logic [1:0] WB_REGISTER = 2'd1;
    localparam logic [1:0] WB_MEMORY   = 2'd2;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_HALTED    = 2'd3;
`ifdef EXEC_MUL_EN
    localparam logic [2:0] CLASS_MUL   = 3'd4;
    localparam logic [1:0] S_MUL_BUSY  = 2'd1;
    localparam logic [1:0] S_MUL_WAIT  = 2'd2;
    localparam int         CW          = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);
`endif

    logic [1:0] state;
    logic       slot_free;
    logic       accept;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == S_IDLE) && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;

    // Slot contents for a single-cycle instruction presented this cycle
    logic [DATA_WIDTH-1:0]    n_result;
    logic [DATA_WIDTH-1:0]    n_data_out;
    logic [ADDRESS_WIDTH-1:0] n_address;
    logic [1:0]               n_writeback;
    logic                     n_read;
    logic                     n_write;
    logic [2*DATA_WIDTH-1:0]  rot;

    always_comb begin
        n_result    = '0;
        n_data_out  = '0;
        n_address   = '0;
        n_writeback = WB_NONE;
        n_read      = 1'b0;
        n_write     = 1'b0;
        rot         = {bus.operand0, bus.operand0} << bus.value;
        case (bus.op_class)
            CLASS_ARITH: begin
                n_writeback = WB_REGISTER;
                n_result    = bus.op_func[0] ? bus.operand1 - bus.operand2
                                             : bus.operand1 + bus.operand2;
            end
            CLASS_LOGIC: begin
                n_writeback = WB_REGISTER;
                case (bus.op_func)
                    3'd0:    n_result = bus.operand1 & bus.operand2;
                    3'd1:    n_result = bus.operand1 | bus.operand2;
                    3'd2:    n_result = bus.operand1 ^ bus.operand2;
                    3'd3:    n_result = ~(bus.operand1 & bus.operand2);
                    3'd4:    n_result = ~(bus.operand1 | bus.operand2);
                    3'd5:    n_result = ~(bus.operand1 ^ bus.operand2);
                    default: n_result = '0;
                endcase
            end
            CLASS_SHIFT: begin
                n_writeback = WB_REGISTER;
                case (bus.op_func)
                    3'd0:    n_result = bus.operand0 >> bus.value;
                    3'd1:    n_result = $unsigned($signed(bus.operand0) >>> bus.value);
                    3'd2:    n_result = bus.operand0 << bus.value;
                    3'd3:    n_result = rot[2*DATA_WIDTH-1:DATA_WIDTH];
                    default: n_result = bus.operand0;
                endcase
            end
            CLASS_MEM: begin
                case (bus.op_func)
                    3'd0: begin
                        n_writeback = WB_REGISTER;
                        n_result    = {bus.operand0[DATA_WIDTH-1:8], bus.constant};
                    end
                    3'd1: begin
                        n_writeback = WB_MEMORY;
                        n_read      = 1'b1;
                        n_address   = bus.operand1[ADDRESS_WIDTH-1:0];
                    end
                    3'd2: begin
                        n_write     = 1'b1;
                        n_address   = bus.operand0[ADDRESS_WIDTH-1:0];
                        n_data_out  = bus.operand1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplier;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [CW-1:0]         count;
    logic [GPR_WIDTH-1:0]  mul_dest;
    logic                  mul_load;
    logic [DATA_WIDTH-1:0] mul_value;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Product enters the slot on the final iteration, or later from MUL_WAIT once the slot frees
    always_comb begin
        mul_load  = 1'b0;
        mul_value = acc;
        if (state == S_MUL_BUSY && count == LAST_ITER && slot_free) begin
            mul_load  = 1'b1;
            mul_value = acc_next;
        end else if (state == S_MUL_WAIT && slot_free) begin
            mul_load  = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.destination <= '0;
            bus.writeback   <= WB_NONE;
            bus.read        <= 1'b0;
            bus.write       <= 1'b0;
            bus.address     <= '0;
            bus.data_out    <= '0;
            bus.halt        <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand           <= '0;
            mplier          <= '0;
            acc             <= '0;
            count           <= '0;
            mul_dest        <= '0;
`endif
        end else begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            if (accept) begin
`ifdef EXEC_MUL_EN
                if (bus.op_class == CLASS_MUL) begin
                    state    <= S_MUL_BUSY;
                    count    <= '0;
                    acc      <= '0;
                    mcand    <= bus.operand1;
                    mplier   <= bus.operand2;
                    mul_dest <= bus.dest_in;
                end else
`endif
                begin
                    bus.out_valid   <= 1'b1;
                    bus.result      <= n_result;
                    bus.destination <= bus.dest_in;
                    bus.writeback   <= n_writeback;
                    bus.read        <= n_read;
                    bus.write       <= n_write;
                    bus.address     <= n_address;
                    bus.data_out    <= n_data_out;
                    if (bus.op_class == CLASS_HALT) begin
                        bus.halt <= 1'b1;
                        state    <= S_HALTED;
                    end
                end
            end
`ifdef EXEC_MUL_EN
            if (state == S_MUL_BUSY) begin
                count  <= count + 1'b1;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_next;
                if (count == LAST_ITER && !slot_free)
                    state <= S_MUL_WAIT;
            end

            if (mul_load) begin
                state           <= S_IDLE;
                bus.out_valid   <= 1'b1;
                bus.result      <= mul_value;
                bus.destination <= mul_dest;
                bus.writeback   <= WB_REGISTER;
                bus.read        <= 1'b0;
                bus.write       <= 1'b0;
                bus.address     <= '0;
                bus.data_out    <= '0;
            end
`endif
        end
    end
endmodule
